uart_loader: RTL
================

// Module: uart_loader
// PURPOSE
// - UART monitor upstream of the CPU: receives framed commands, writes program bytes into the shared 512x8 RAM,
//   then launches the CPU at a chosen address and reports when it halts. Owns RAM write port + UART TX while CPU idle.
// PARAMETERS
// - TIMEOUT_CYCLES  12_000_000  max clk cycles between bytes of one frame before abort (1 s @ 12 MHz)
// - ADDR_W          9           RAM address width
// PORTS
// - clk            in   1       clock
// - rst            in   1       reset: synchronous, active-high
// - rx_byte        in   8       received UART byte, valid when received=1
// - received       in   1       one-cycle strobe from UART RX
// - tx_byte        out  8       byte to UART TX
// - transmit       out  1       one-cycle TX request
// - is_transmitting in  1       UART TX busy
// - ram_waddr      out  ADDR_W  RAM write address
// - ram_wdata      out  8       RAM write data
// - ram_we         out  1       RAM write enable, one cycle per byte
// - cpu_start      out  1       one-cycle launch pulse to CPU (drives CPU rst/start input)
// - cpu_startaddr  out  ADDR_W  CPU start address, stable from cpu_start until next G frame
// - cpu_halted     in   1       one-cycle strobe from CPU on HLT
// - cpu_running    out  1       1 = CPU owns RAM write port, UART TX and RX; top-level muxes on it
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, address/len/checksum registers 0. Reset mid-frame discards frame; no reply.
// - Frames (bytes in order): 'L'(0x4C) addr_hi addr_lo len data[len]; 'G'(0x47) addr_hi addr_lo.
//   addr = {addr_hi[0], addr_lo}; addr_hi[7:1] ignored. len=0 -> no data bytes, immediate reply.
// - Replies: 'K'(0x4B) load ok; 'H'(0x48) CPU halted; '?'(0x3F) unknown cmd; 'T'(0x54) timeout; 'E'(0x45) checksum bad.
// - States: IDLE, ADDR_HI, ADDR_LO, LEN, DATA, CSUM, LAUNCH, RUN, REPLY_WAIT, REPLY_SEND.
//   IDLE: on received: 'L'/'G' -> ADDR_HI; other -> reply '?'. Bytes only consumed on received=1.
//   ADDR_HI -> ADDR_LO -> (L: LEN; G: LAUNCH). LEN: len=0 -> CSUM or reply 'K'; else DATA.
//   DATA: each byte -> next cycle ram_we=1, ram_waddr=addr, ram_wdata=byte; addr+1 wraps 511->0; after len-th byte
//   -> CSUM or reply 'K'. Writes past wrap silently overwrite low RAM.
//   LAUNCH: one cycle, cpu_start=1, cpu_startaddr=addr, cpu_running=1 -> RUN.
//   RUN: cpu_running=1; received ignored (CPU INA consumes it); no timeout; on cpu_halted -> cpu_running=0, reply 'H'.
//   REPLY_WAIT: wait !is_transmitting; REPLY_SEND: tx_byte=reply, transmit=1 for one cycle -> IDLE.
// - Timeout: counter clears on every received; in ADDR_HI..CSUM reaching TIMEOUT_CYCLES-1 -> reply 'T', frame dropped
//   (already written bytes stay). Counter idle in IDLE/RUN/LAUNCH/REPLY_*.
// - received coincident with timeout expiry: byte wins, counter clears. received during REPLY_* : dropped.
// - cpu_halted outside RUN ignored. transmit never asserted while cpu_running=1.
// CONFIGURATION
// - LOADER_CHECKSUM_EN defined: L frame carries one extra byte after data = 8-bit sum (mod 256) of data bytes;
//   CSUM state compares: match -> 'K', mismatch -> 'E' (data already written, not rolled back).
// - Undefined: no checksum byte, CSUM state absent, L always replies 'K'.
// STRUCTURE
// - loader_pkg: command/reply byte constants, state encoding localparams, TIMEOUT default.
// - Sub-module loader_timeout: TIMEOUT_CYCLES counter with clear/enable in, expired strobe out.
// TESTING
// - 'L',0x00,0x10,3,0xAA,0xBB,0xCC -> ram_we pulses at 0x010/011/012 with AA/BB/CC, then tx 0x4B.
// - 'L',0x01,0xFF,2,0x11,0x22 -> writes 0x1FF=0x11, 0x000=0x22 (wrap), tx 'K'.
// - 'G',0x00,0x20 -> cpu_start 1 cycle, cpu_startaddr=0x020, cpu_running=1; bytes ignored; cpu_halted -> tx 'H'.
// - 'X'(0x58) -> tx '?'; 'L',0x00 then silence TIMEOUT_CYCLES (bench TIMEOUT_CYCLES=100) -> tx 'T', IDLE.
// - With LOADER_CHECKSUM_EN: 'L',0,0,2,0x01,0x02,0x03 -> 'K'; checksum 0x04 -> 'E'.
// - is_transmitting held high 50 cycles at reply -> transmit waits; rst mid-DATA -> outputs 0, no reply.

Source files
------------

// File: rtl/uart_loader_pkg.sv
// Shared constants and state encoding for the UART program loader.
// The build macro LOADER_CHECKSUM_EN adds the trailing checksum byte to L frames.
package uart_loader_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 12_000_000;
  localparam int unsigned ADDR_W_DEFAULT  = 9;

  localparam logic [7:0] CMD_LOAD     = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_GO       = 8'h47;  // 'G'
  localparam logic [7:0] RPL_OK       = 8'h4B;  // 'K'
  localparam logic [7:0] RPL_HALT     = 8'h48;  // 'H'
  localparam logic [7:0] RPL_UNKNOWN  = 8'h3F;  // '?'
  localparam logic [7:0] RPL_TIMEOUT  = 8'h54;  // 'T'
  localparam logic [7:0] RPL_CSUM_BAD = 8'h45;  // 'E'

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_ADDR_HI    = 4'd1,
    ST_ADDR_LO    = 4'd2,
    ST_LEN        = 4'd3,
    ST_DATA       = 4'd4,
`ifdef LOADER_CHECKSUM_EN
    ST_CSUM       = 4'd5,
`endif
    ST_LAUNCH     = 4'd6,
    ST_RUN        = 4'd7,
    ST_REPLY_WAIT = 4'd8,
    ST_REPLY_SEND = 4'd9
  } state_t;

  // States in which a frame is partially received and the inter-byte timer runs.
  function automatic logic in_frame(state_t s);
    logic r;
    r = (s == ST_ADDR_HI) || (s == ST_ADDR_LO) || (s == ST_LEN) || (s == ST_DATA);
`ifdef LOADER_CHECKSUM_EN
    r = r || (s == ST_CSUM);
`endif
    return r;
  endfunction

endpackage

// File: rtl/uart_loader_if.sv
// Loader-facing bundle of UART RX/TX, RAM write port and CPU control signals.
// master = the loader, slave = the surrounding system (UART, RAM, CPU).
interface uart_loader_if #(
  parameter int ADDR_W = 9
);
  logic [7:0]        rx_byte;
  logic              received;
  logic [7:0]        tx_byte;
  logic              transmit;
  logic              is_transmitting;
  logic [ADDR_W-1:0] ram_waddr;
  logic [7:0]        ram_wdata;
  logic              ram_we;
  logic              cpu_start;
  logic [ADDR_W-1:0] cpu_startaddr;
  logic              cpu_halted;
  logic              cpu_running;

  modport master (
    input  rx_byte, received, is_transmitting, cpu_halted,
    output tx_byte, transmit, ram_waddr, ram_wdata, ram_we,
           cpu_start, cpu_startaddr, cpu_running
  );

  modport slave (
    output rx_byte, received, is_transmitting, cpu_halted,
    input  tx_byte, transmit, ram_waddr, ram_wdata, ram_we,
           cpu_start, cpu_startaddr, cpu_running
  );
endinterface

// File: rtl/uart_loader_timeout.sv
// Inter-byte watchdog: counts while enabled, restarts on every received byte,
// and flags expiry when the count reaches TIMEOUT_CYCLES-1.
module loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 12_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear || !i_enable) begin
      r_count <= '0;
    end else if (!o_expired) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // A byte arriving on the expiry cycle wins over the timeout.
  assign o_expired = i_enable && !i_clear && (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/uart_loader.sv
// UART monitor: parses L (load) / G (go) frames, writes RAM, launches the CPU and
// sends one-byte replies. Optional checksum byte on L frames via LOADER_CHECKSUM_EN.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int unsigned ADDR_W         = ADDR_W_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  uart_loader_if.master bus
);
  state_t            r_state, w_state;
  logic [ADDR_W-1:0] r_addr, r_waddr, r_startaddr;
  logic [7:0]        r_cnt, r_wdata, r_reply, w_reply;
  logic              r_we, r_is_load;
  logic              w_set_reply, w_data_done, w_expired;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  loader_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (bus.received),
    .i_enable  (in_frame(r_state)),
    .o_expired (w_expired)
  );

  // NOTE: sequential state uses <= so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state;
  end

  // NOTE: every output of this block is defaulted first, so no path infers a latch.
  always_comb begin
    w_state     = r_state;
    w_set_reply = 1'b0;
    w_reply     = RPL_OK;
    w_data_done = 1'b0;
    case (r_state)
      ST_IDLE: if (bus.received) begin
        if (bus.rx_byte == CMD_LOAD || bus.rx_byte == CMD_GO) begin
          w_state = ST_ADDR_HI;
        end else begin
          w_state     = ST_REPLY_WAIT;
          w_set_reply = 1'b1;
          w_reply     = RPL_UNKNOWN;
        end
      end
      ST_ADDR_HI: if (bus.received) w_state = ST_ADDR_LO;
      ST_ADDR_LO: if (bus.received) w_state = r_is_load ? ST_LEN : ST_LAUNCH;
      ST_LEN: if (bus.received) begin
        if (bus.rx_byte == 8'd0) w_data_done = 1'b1;
        else                     w_state     = ST_DATA;
      end
      ST_DATA: if (bus.received && r_cnt == 8'd1) w_data_done = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      ST_CSUM: if (bus.received) begin
        w_state     = ST_REPLY_WAIT;
        w_set_reply = 1'b1;
        w_reply     = (bus.rx_byte == r_csum) ? RPL_OK : RPL_CSUM_BAD;
      end
`endif
      ST_LAUNCH: w_state = ST_RUN;
      ST_RUN: if (bus.cpu_halted) begin
        w_state     = ST_REPLY_WAIT;
        w_set_reply = 1'b1;
        w_reply     = RPL_HALT;
      end
      ST_REPLY_WAIT: if (!bus.is_transmitting) w_state = ST_REPLY_SEND;
      ST_REPLY_SEND: w_state = ST_IDLE;
      default:       w_state = ST_IDLE;
    endcase

    if (w_data_done) begin
`ifdef LOADER_CHECKSUM_EN
      w_state = ST_CSUM;
`else
      w_state     = ST_REPLY_WAIT;
      w_set_reply = 1'b1;
      w_reply     = RPL_OK;
`endif
    end

    if (w_expired) begin
      w_state     = ST_REPLY_WAIT;
      w_set_reply = 1'b1;
      w_reply     = RPL_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_waddr     <= '0;
      r_startaddr <= '0;
      r_cnt       <= '0;
      r_wdata     <= '0;
      r_reply     <= '0;
      r_we        <= 1'b0;
      r_is_load   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_csum      <= '0;
`endif
    end else begin
      r_we <= 1'b0;
      if (w_set_reply) r_reply <= w_reply;
      if (bus.received) begin
        case (r_state)
          ST_IDLE: begin
            r_is_load <= (bus.rx_byte == CMD_LOAD);
`ifdef LOADER_CHECKSUM_EN
            r_csum    <= '0;
`endif
          end
          // Only the low bits of addr_hi that fit the RAM address are kept.
          ST_ADDR_HI: r_addr[ADDR_W-1:8] <= bus.rx_byte[ADDR_W-9:0];
          ST_ADDR_LO: begin
            r_addr[7:0] <= bus.rx_byte;
            if (!r_is_load) r_startaddr <= {r_addr[ADDR_W-1:8], bus.rx_byte};
          end
          ST_LEN: r_cnt <= bus.rx_byte;
          ST_DATA: begin
            r_we    <= 1'b1;
            r_waddr <= r_addr;
            r_wdata <= bus.rx_byte;
            r_addr  <= r_addr + ADDR_W'(1);
            r_cnt   <= r_cnt - 8'd1;
`ifdef LOADER_CHECKSUM_EN
            r_csum  <= r_csum + bus.rx_byte;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.ram_we        = r_we;
  assign bus.ram_waddr     = r_waddr;
  assign bus.ram_wdata     = r_wdata;
  assign bus.cpu_startaddr = r_startaddr;
  assign bus.cpu_start     = (r_state == ST_LAUNCH);
  assign bus.cpu_running   = (r_state == ST_LAUNCH) || (r_state == ST_RUN);
  assign bus.transmit      = (r_state == ST_REPLY_SEND);
  assign bus.tx_byte       = (r_state == ST_REPLY_SEND) ? r_reply : 8'h00;

endmodule
